vga_color_sequencer: RTL and testbench
======================================

// Module: vga_color_sequencer
// PURPOSE
//  Controller that sequences the colour index driving the VGA palette/colour mux.
//  Selects the index manually (step button) or automatically (every N frames), or freezes it.
//  Applies every index change only at frame start (vsync assertion), so no frame shows two colours.
//  Sits between the button inputs / VGA_display_driver vsync and the top-level colour case logic.
// PARAMETERS
//  NUM_COLORS       8   number of palette entries; index wraps NUM_COLORS-1 -> 0 (2..16)
//  FRAMES_PER_STEP  60  frames per advance in AUTO mode (>=1)
//  FCNT_W           8   frame counter width; must hold FRAMES_PER_STEP-1
// PORTS
//  clk         in   1  system clock; single domain
//  rst         in   1  asynchronous, active-high reset
//  btn_step    in   1  raw step button; synchronised internally
//  btn_mode    in   1  raw mode button; synchronised internally
//  vsync       in   1  vsync from VGA_display_driver, same clk domain, active-low
//  color_idx   out  4  current palette index
//  mode        out  2  00 MANUAL, 01 AUTO, 10 HOLD
//  frame_tick  out  1  one-cycle pulse per frame start
// BEHAVIOUR
//  Reset (async): color_idx=0, mode=MANUAL, frame_tick=0, frame counter=0, step_pending=0,
//   sync flops=0, vsync_q=1.
//  Button path: 2-flop synchroniser, then rising-edge detect -> 1-cycle press pulse.
//   Raw edge to pulse latency = 3 clk. A held button gives exactly one pulse.
//  frame_tick: registered. vsync_q <= vsync; frame_tick <= vsync_q & ~vsync.
//   Goes high the cycle after vsync falls, for exactly 1 clk.
//  Mode FSM (on mode press): MANUAL -> AUTO -> HOLD -> MANUAL.
//   Every mode change clears step_pending and the frame counter. color_idx is unchanged.
//  MANUAL
//   - A step press sets step_pending. Several presses within one frame still count as one step.
//   - On a frame_tick cycle with step_pending=1: color_idx advances by 1 (with wrap) and
//     step_pending clears. New value is visible the next cycle.
//   - A step press in the same cycle as frame_tick is held pending for the next frame.
//  AUTO
//   - On each frame_tick: if fcnt == FRAMES_PER_STEP-1, then fcnt <= 0 and color_idx advances;
//     otherwise fcnt increments.
//   - Step presses are ignored.
//  HOLD: color_idx frozen; fcnt held at 0; step presses ignored.
//  Simultaneous events
//   - Mode press and step press in the same cycle: mode wins; the step is discarded.
//   - Mode press on a frame_tick cycle: the mode change is taken; no advance that cycle.
//  Wrap arithmetic: next = (color_idx == NUM_COLORS-1) ? 0 : color_idx + 1.
//   Never produce an index >= NUM_COLORS.
//  Reset mid-frame or mid-press: immediate return to reset values. A button still held after
//   reset release produces no pulse until it is released and pressed again.
// STRUCTURE
//  Shared package vga_pkg: mode encodings MODE_MANUAL/MODE_AUTO/MODE_HOLD, default
//   NUM_COLORS, colour index width (4).
//  Sub-module btn_edge_sync (2-flop sync + rising-edge pulse), instantiated for btn_step and
//   btn_mode.
//  Top-level contents: vsync edge register, frame counter, mode FSM, index register.
// TESTING (sim with FRAMES_PER_STEP=3, NUM_COLORS=8, vsync period 100 clk)
//  1. Assert rst mid-run -> color_idx=0, mode=00, frame_tick=0 with no clock edge.
//     Release rst -> these values hold.
//  2. MANUAL, one step press at frame start + 20 clk -> color_idx 0->1 the cycle after the
//     next frame_tick. Check that it does not change before.
//  3. MANUAL, 3 presses within one frame -> single advance (1->2). A press on the frame_tick
//     cycle -> advance at the following frame.
//  4. AUTO from idx 6 -> idx 7 after 3 frame_ticks, then 0 after 3 more (wrap).
//     Step presses have no effect.
//  5. Mode and step pressed in the same cycle in MANUAL -> mode=01, idx unchanged,
//     no pending step. Mode again -> 10 and idx frozen over 10 frames.
//     Mode again -> 00 (wrap).
//  6. Hold btn_step high across reset release -> no advance until release and re-press.
//     frame_tick width = 1 clk, exactly once per vsync fall.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: mode encodings, index width and index/mode stepping helpers for the colour sequencer
package vga_pkg;
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_HOLD   = 2'b10
  } mode_e;
  localparam int IDX_W = 4;
  localparam int DEF_NUM_COLORS = 8;
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int unsigned n);
    return (idx >= IDX_W'(n - 1)) ? '0 : idx + 1'b1;
  endfunction
  function automatic mode_e next_mode(input mode_e m);
    return m == MODE_MANUAL ? MODE_AUTO : m == MODE_AUTO ? MODE_HOLD : MODE_MANUAL;
  endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser plus registered rising-edge pulse for a raw button
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);
  logic r_s1, r_s2, r_s3, r_armed, r_pulse;
  logic [1:0] r_vld;
  // r_armed only sets once a genuine low sample has passed the synchroniser,
  // so a button held through reset cannot fire until released and re-pressed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_vld   <= '0;
      r_armed <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & ~r_s2);
      r_pulse <= r_armed & r_s2 & ~r_s3;
    end
  assign o_pulse = r_pulse;
endmodule

// File: rtl/vga_color_sequencer.sv
// vga_color_sequencer: steps the palette index manually or every N frames, applied only at frame start
module vga_color_sequencer
  import vga_pkg::*;
#(
  parameter int NUM_COLORS      = DEF_NUM_COLORS,
  parameter int FRAMES_PER_STEP = 60,
  parameter int FCNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             vsync,
  output logic [IDX_W-1:0] color_idx,
  output logic [1:0]       mode,
  output logic             frame_tick
);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_STEP - 1);
  logic w_step, w_mode;
  logic r_vsync_q, r_frame_tick, r_pend;
  mode_e r_mode;
  logic [IDX_W-1:0] r_idx;
  logic [FCNT_W-1:0] r_fcnt;
  btn_edge_sync u_step (.clk(clk), .rst(rst), .i_btn(btn_step), .o_pulse(w_step));
  btn_edge_sync u_mode (.clk(clk), .rst(rst), .i_btn(btn_mode), .o_pulse(w_mode));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_vsync_q    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_frame_tick <= r_vsync_q & ~vsync;
    end
  // a mode press pre-empts both a same-cycle step and a same-cycle frame advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mode <= MODE_MANUAL;
      r_idx  <= '0;
      r_fcnt <= '0;
      r_pend <= 1'b0;
    end else if (w_mode) begin
      r_mode <= next_mode(r_mode);
      r_fcnt <= '0;
      r_pend <= 1'b0;
    end else begin
      case (r_mode)
        MODE_MANUAL: begin
          if (r_frame_tick && r_pend) r_idx <= wrap_inc(r_idx, NUM_COLORS);
          r_pend <= w_step | (r_pend & ~r_frame_tick);
        end
        MODE_AUTO:
          if (r_frame_tick) begin
            r_fcnt <= (r_fcnt == FCNT_LAST) ? '0 : r_fcnt + 1'b1;
            if (r_fcnt == FCNT_LAST) r_idx <= wrap_inc(r_idx, NUM_COLORS);
          end
        default: begin
          r_fcnt <= '0;
          r_pend <= 1'b0;
        end
      endcase
    end
  assign color_idx  = r_idx;
  assign mode       = r_mode;
  assign frame_tick = r_frame_tick;
endmodule

// File: tb/tb_vga_color_sequencer.sv
// tb_vga_color_sequencer: random button/vsync stimulus against a frame-level reference model
module tb_vga_color_sequencer;
  localparam int NC = 8;
  localparam int FPS = 3;
  logic clk = 1'b0, rst = 1'b1, btn_step = 1'b0, btn_mode = 1'b0, vsync = 1'b1;
  logic [3:0] color_idx;
  logic [1:0] mode;
  logic frame_tick;
  int n_vec = 0, n_err = 0, cyc = 0;
  int sh[5], mh[5];
  int vq, m_idx, m_mode, m_pend, m_fcnt, m_ft;

  vga_color_sequencer #(.NUM_COLORS(NC), .FRAMES_PER_STEP(FPS), .FCNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_mode(btn_mode), .vsync(vsync),
    .color_idx(color_idx), .mode(mode), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 5; i++) begin
      sh[i] = -1;
      mh[i] = -1;
    end
    vq = 1;
    m_idx = 0; m_mode = 0; m_pend = 0; m_fcnt = 0; m_ft = 0;
  endtask

  // a press counts 3 edges after a sampled low->high, and only if that low was seen after reset
  task automatic m_step();
    bit sp, mp, tk;
    for (int i = 4; i > 0; i--) begin
      sh[i] = sh[i-1];
      mh[i] = mh[i-1];
    end
    sh[0] = int'(btn_step);
    mh[0] = int'(btn_mode);
    sp = sh[3] == 1 && sh[4] == 0;
    mp = mh[3] == 1 && mh[4] == 0;
    tk = m_ft != 0;
    if (mp) begin
      m_mode = (m_mode + 1) % 3;
      m_pend = 0;
      m_fcnt = 0;
    end else if (m_mode == 0) begin
      if (tk && m_pend != 0) begin
        m_idx = (m_idx + 1) % NC;
        m_pend = 0;
      end
      if (sp) m_pend = 1;
    end else if (m_mode == 1 && tk) begin
      m_fcnt++;
      if (m_fcnt == FPS) begin
        m_fcnt = 0;
        m_idx = (m_idx + 1) % NC;
      end
    end
    m_ft = (vq == 1 && vsync == 1'b0) ? 1 : 0;
    vq = int'(vsync);
  endtask

  task automatic cycle_();
    @(posedge clk);
    m_step();
    @(negedge clk);
    chk("idx", 8'(color_idx), 8'(m_idx));
    chk("mode", 8'(mode), 8'(m_mode));
    chk("tick", 8'(frame_tick), 8'(m_ft));
    cyc++;
    vsync = (cyc % 100) >= 4;
  endtask

  task automatic run(input int n, input int ps, input int pm);
    repeat (n) begin
      btn_step = btn_step ? ($urandom_range(2) != 0) : ($urandom_range(99) < ps);
      btn_mode = btn_mode ? ($urandom_range(2) != 0) : ($urandom_range(99) < pm);
      cycle_();
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("rst_idx", 8'(color_idx), 8'd0);
    chk("rst_mode", 8'(mode), 8'd0);
    chk("rst_tick", 8'(frame_tick), 8'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold_idx", 8'(color_idx), 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    chk("init_idx", 8'(color_idx), 8'd0);
    chk("init_mode", 8'(mode), 8'd0);
    chk("init_tick", 8'(frame_tick), 8'd0);
    rst = 1'b0;
    vsync = 1'b0;
    run(1500, 3, 0);
    btn_step = 1'b0;
    run(100, 0, 0);
    // step presses landing around the frame-start boundary
    for (int o = 0; o < 8; o++) begin
      for (int k = 0; k < 100 && (cyc % 100) != (96 + o) % 100; k++) cycle_();
      btn_step = 1'b1;
      cycle_();
      btn_step = 1'b0;
      run(250, 0, 0);
    end
    run(137, 5, 0);
    do_reset();
    btn_step = 1'b0;
    run(50, 0, 0);
    btn_step = 1'b1;
    btn_mode = 1'b1;
    repeat (3) cycle_();
    btn_step = 1'b0;
    btn_mode = 1'b0;
    run(300, 0, 0);
    run(3000, 3, 0);
    btn_step = 1'b0;
    btn_mode = 1'b1;
    repeat (2) cycle_();
    btn_mode = 1'b0;
    run(1100, 3, 0);
    btn_step = 1'b0;
    btn_mode = 1'b1;
    repeat (2) cycle_();
    btn_mode = 1'b0;
    run(500, 3, 0);
    btn_step = 1'b1;
    btn_mode = 1'b0;
    do_reset();
    repeat (300) cycle_();
    btn_step = 1'b0;
    run(400, 3, 0);
    run(6000, 2, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
